// File: rtl/cuenta_regresiva_rtc_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding and BCD constants.
package cuenta_regresiva_rtc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSA = 2'd2,
      FIN   = 2'd3
   } estado_t;

   localparam logic [7:0] BCD_59   = 8'h59;
   localparam logic [7:0] BCD_CERO = 8'h00;

endpackage

// File: rtl/cuenta_regresiva_rtc_decremento_bcd_hms.sv
// Combinational one-second decrement of a BCD hh:mm:ss value.
// The borrow out of hours is never needed: the caller never decrements 00:00:00.
module decremento_bcd_hms
   import cuenta_regresiva_rtc_pkg::*;
(
   input  logic [7:0] i_hh,
   input  logic [7:0] i_mm,
   input  logic [7:0] i_ss,
   output logic [7:0] o_hh,
   output logic [7:0] o_mm,
   output logic [7:0] o_ss,
   output logic       o_es_cero
);

   logic w_borrow_ss;
   logic w_borrow_mm;

   // Digit-by-digit borrow chain: seconds, then minutes, then hours.
   always_comb begin
      w_borrow_ss = 1'b0;
      w_borrow_mm = 1'b0;
      o_ss        = i_ss;
      o_mm        = i_mm;
      o_hh        = i_hh;

      if (i_ss[3:0] == 4'd0) begin
         if (i_ss[7:4] == 4'd0) begin
            o_ss        = BCD_59;
            w_borrow_ss = 1'b1;
         end else begin
            o_ss = {i_ss[7:4] - 4'd1, 4'd9};
         end
      end else begin
         o_ss = {i_ss[7:4], i_ss[3:0] - 4'd1};
      end

      if (w_borrow_ss) begin
         if (i_mm[3:0] == 4'd0) begin
            if (i_mm[7:4] == 4'd0) begin
               o_mm        = BCD_59;
               w_borrow_mm = 1'b1;
            end else begin
               o_mm = {i_mm[7:4] - 4'd1, 4'd9};
            end
         end else begin
            o_mm = {i_mm[7:4], i_mm[3:0] - 4'd1};
         end
      end else begin
         o_mm = i_mm;
      end

      if (w_borrow_mm) begin
         if (i_hh[3:0] == 4'd0) begin
            o_hh = {i_hh[7:4] - 4'd1, 4'd9};
         end else begin
            o_hh = {i_hh[7:4], i_hh[3:0] - 4'd1};
         end
      end else begin
         o_hh = i_hh;
      end
   end

   assign o_es_cero = (o_hh == BCD_CERO) && (o_mm == BCD_CERO) && (o_ss == BCD_CERO);

endmodule

// File: rtl/cuenta_regresiva_rtc.sv
// BCD hh:mm:ss countdown timer driven by a 1 Hz tick, with load validation,
// pause/resume, terminal-count alarm and optional auto-reload.
module cuenta_regresiva_rtc
   import cuenta_regresiva_rtc_pkg::*;
#(
   parameter logic [7:0] HORA_MAX    = 8'h23,
   parameter bit         AUTORECARGA = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cargar,
   input  logic [7:0] hora_set,
   input  logic [7:0] minuto_set,
   input  logic [7:0] segundo_set,
   input  logic       iniciar,
   input  logic       pausar,
   input  logic       ack_fin,
   input  logic       tick_1hz,
   output logic [7:0] hora_out,
   output logic [7:0] minuto_out,
   output logic [7:0] segundo_out,
   output logic       corriendo,
   output logic       fin,
   output logic       alarma,
   output logic       error_carga
);

   // A byte is a legal setpoint field when both nibbles are decimal and it does not exceed its limit.
   function automatic logic bcd_valido(input logic [7:0] v, input logic [7:0] maximo);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= maximo);
   endfunction

   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   estado_t    r_estado, w_estado;
   logic [7:0] r_hora, r_minuto, r_segundo;
   logic [7:0] w_hora, w_minuto, w_segundo;
   logic [7:0] r_sp_hora, r_sp_minuto, r_sp_segundo;
   logic [7:0] w_sp_hora, w_sp_minuto, w_sp_segundo;
   logic       r_fin, w_fin;
   logic       r_alarma, w_alarma;
   logic       r_error, w_error;
   logic       r_corriendo, w_corriendo;

   logic [7:0] w_dec_hh, w_dec_mm, w_dec_ss;
   logic       w_dec_cero;
   logic       w_carga_ok;
   logic       w_actual_cero;

   // Reset asserts immediately and releases only after two clean clock edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   decremento_bcd_hms u_decremento (
      .i_hh      (r_hora),
      .i_mm      (r_minuto),
      .i_ss      (r_segundo),
      .o_hh      (w_dec_hh),
      .o_mm      (w_dec_mm),
      .o_ss      (w_dec_ss),
      .o_es_cero (w_dec_cero)
   );

   assign w_carga_ok = bcd_valido(hora_set, HORA_MAX) &&
                       bcd_valido(minuto_set, BCD_59) &&
                       bcd_valido(segundo_set, BCD_59);

   assign w_actual_cero = (r_hora == BCD_CERO) && (r_minuto == BCD_CERO) && (r_segundo == BCD_CERO);

   // Next-state and next-output decode; strobes resolved in priority cargar > ack_fin > pausar > iniciar > tick.
   always_comb begin
      w_estado     = r_estado;
      w_hora       = r_hora;
      w_minuto     = r_minuto;
      w_segundo    = r_segundo;
      w_sp_hora    = r_sp_hora;
      w_sp_minuto  = r_sp_minuto;
      w_sp_segundo = r_sp_segundo;
      w_fin        = r_fin;
      w_alarma     = 1'b0;
      w_error      = 1'b0;

      if (cargar) begin
         if (w_carga_ok) begin
            w_hora       = hora_set;
            w_minuto     = minuto_set;
            w_segundo    = segundo_set;
            w_sp_hora    = hora_set;
            w_sp_minuto  = minuto_set;
            w_sp_segundo = segundo_set;
            w_estado     = IDLE;
            w_fin        = 1'b0;
         end else begin
            w_error = 1'b1;
         end
      end else if (ack_fin) begin
         // fin is cleared in any state so an auto-reloading timer can acknowledge while it keeps running.
         w_fin = 1'b0;
         if (r_estado == FIN) begin
            w_estado = IDLE;
         end else begin
            w_estado = r_estado;
         end
      end else if (pausar) begin
         if (r_estado == RUN) begin
            w_estado = PAUSA;
         end else begin
            w_estado = r_estado;
         end
      end else if (iniciar) begin
         if (((r_estado == IDLE) || (r_estado == PAUSA)) && !w_actual_cero) begin
            w_estado = RUN;
         end else begin
            w_estado = r_estado;
         end
      end else if (tick_1hz && (r_estado == RUN)) begin
         if (w_dec_cero) begin
            w_alarma = 1'b1;
            w_fin    = 1'b1;
            if (AUTORECARGA) begin
               w_hora    = r_sp_hora;
               w_minuto  = r_sp_minuto;
               w_segundo = r_sp_segundo;
               w_estado  = RUN;
            end else begin
               w_hora    = BCD_CERO;
               w_minuto  = BCD_CERO;
               w_segundo = BCD_CERO;
               w_estado  = FIN;
            end
         end else begin
            w_hora    = w_dec_hh;
            w_minuto  = w_dec_mm;
            w_segundo = w_dec_ss;
         end
      end else begin
         w_estado = r_estado;
      end

      w_corriendo = (w_estado == RUN);
   end

   // State, time, setpoint and flag registers.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_estado     <= IDLE;
         r_hora       <= BCD_CERO;
         r_minuto     <= BCD_CERO;
         r_segundo    <= BCD_CERO;
         r_sp_hora    <= BCD_CERO;
         r_sp_minuto  <= BCD_CERO;
         r_sp_segundo <= BCD_CERO;
         r_fin        <= 1'b0;
         r_alarma     <= 1'b0;
         r_error      <= 1'b0;
         r_corriendo  <= 1'b0;
      end else begin
         r_estado     <= w_estado;
         r_hora       <= w_hora;
         r_minuto     <= w_minuto;
         r_segundo    <= w_segundo;
         r_sp_hora    <= w_sp_hora;
         r_sp_minuto  <= w_sp_minuto;
         r_sp_segundo <= w_sp_segundo;
         r_fin        <= w_fin;
         r_alarma     <= w_alarma;
         r_error      <= w_error;
         r_corriendo  <= w_corriendo;
      end
   end

   assign hora_out    = r_hora;
   assign minuto_out  = r_minuto;
   assign segundo_out = r_segundo;
   assign corriendo   = r_corriendo;
   assign fin         = r_fin;
   assign alarma      = r_alarma;
   assign error_carga = r_error;

endmodule

// File: tb/tb_cuenta_regresiva_rtc.sv
// Directed testbench for cuenta_regresiva_rtc: one stopping instance and one auto-reloading instance.
module tb_cuenta_regresiva_rtc;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cargar = 1'b0;
   logic [7:0] hora_set = 8'h00;
   logic [7:0] minuto_set = 8'h00;
   logic [7:0] segundo_set = 8'h00;
   logic       iniciar = 1'b0;
   logic       pausar = 1'b0;
   logic       ack_fin = 1'b0;
   logic       tick_1hz = 1'b0;

   logic [7:0] hora_out, minuto_out, segundo_out;
   logic       corriendo, fin, alarma, error_carga;
   logic [7:0] ar_hora, ar_minuto, ar_segundo;
   logic       ar_corriendo, ar_fin, ar_alarma, ar_error;

   logic [23:0] t;
   logic [23:0] t_ar;
   assign t    = {hora_out, minuto_out, segundo_out};
   assign t_ar = {ar_hora, ar_minuto, ar_segundo};

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   cuenta_regresiva_rtc #(.HORA_MAX(8'h23), .AUTORECARGA(1'b0)) dut (
      .clk(clk), .reset(reset), .cargar(cargar), .hora_set(hora_set),
      .minuto_set(minuto_set), .segundo_set(segundo_set), .iniciar(iniciar),
      .pausar(pausar), .ack_fin(ack_fin), .tick_1hz(tick_1hz),
      .hora_out(hora_out), .minuto_out(minuto_out), .segundo_out(segundo_out),
      .corriendo(corriendo), .fin(fin), .alarma(alarma), .error_carga(error_carga)
   );

   cuenta_regresiva_rtc #(.HORA_MAX(8'h23), .AUTORECARGA(1'b1)) dut_ar (
      .clk(clk), .reset(reset), .cargar(cargar), .hora_set(hora_set),
      .minuto_set(minuto_set), .segundo_set(segundo_set), .iniciar(iniciar),
      .pausar(pausar), .ack_fin(ack_fin), .tick_1hz(tick_1hz),
      .hora_out(ar_hora), .minuto_out(ar_minuto), .segundo_out(ar_segundo),
      .corriendo(ar_corriendo), .fin(ar_fin), .alarma(ar_alarma), .error_carga(ar_error)
   );

   task automatic paso();
      @(posedge clk);
      #1;
   endtask

   task automatic cargar_valor(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      hora_set = h; minuto_set = m; segundo_set = s; cargar = 1'b1;
      paso();
      cargar = 1'b0;
   endtask

   task automatic pulso_iniciar();
      iniciar = 1'b1; paso(); iniciar = 1'b0;
   endtask

   task automatic pulso_tick();
      tick_1hz = 1'b1; paso(); tick_1hz = 1'b0;
   endtask

   task automatic pulso_ack();
      ack_fin = 1'b1; paso(); ack_fin = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      paso(); paso();
      tests_run++; if ({t, corriendo, fin, alarma, error_carga} !== 28'h0) begin tests_failed++; $display("FAIL reset_held: got %h expected %h", {t, corriendo, fin, alarma, error_carga}, 28'h0); end
      reset = 1'b1;
      paso(); paso(); paso();
      tests_run++; if ({t, corriendo, fin, alarma, error_carga} !== 28'h0) begin tests_failed++; $display("FAIL reset_released: got %h expected %h", {t, corriendo, fin, alarma, error_carga}, 28'h0); end
   endtask

   task automatic test_cuenta_basica();
      cargar_valor(8'h00, 8'h01, 8'h00);
      tests_run++; if ({t, corriendo} !== {24'h000100, 1'b0}) begin tests_failed++; $display("FAIL basic_load: got %h expected %h", {t, corriendo}, {24'h000100, 1'b0}); end
      pulso_iniciar();
      tests_run++; if (corriendo !== 1'b1) begin tests_failed++; $display("FAIL basic_start: got %b expected %b", corriendo, 1'b1); end
      pulso_tick();
      tests_run++; if (t !== 24'h000059) begin tests_failed++; $display("FAIL basic_tick1: got %h expected %h", t, 24'h000059); end
      pulso_tick();
      tests_run++; if ({t, corriendo} !== {24'h000058, 1'b1}) begin tests_failed++; $display("FAIL basic_tick2: got %h expected %h", {t, corriendo}, {24'h000058, 1'b1}); end
   endtask

   task automatic test_borrow_hora();
      cargar_valor(8'h10, 8'h00, 8'h00);
      pulso_iniciar();
      pulso_tick();
      tests_run++; if (t !== 24'h095959) begin tests_failed++; $display("FAIL borrow_hour: got %h expected %h", t, 24'h095959); end
      cargar_valor(8'h00, 8'h10, 8'h00);
      pulso_iniciar();
      pulso_tick();
      tests_run++; if (t !== 24'h000959) begin tests_failed++; $display("FAIL borrow_minute_tens: got %h expected %h", t, 24'h000959); end
      cargar_valor(8'h01, 8'h20, 8'h30);
      pulso_iniciar();
      pulso_tick();
      tests_run++; if (t !== 24'h012029) begin tests_failed++; $display("FAIL borrow_sec_tens: got %h expected %h", t, 24'h012029); end
   endtask

   task automatic test_expiracion();
      cargar_valor(8'h00, 8'h00, 8'h02);
      pulso_iniciar();
      pulso_tick();
      tests_run++; if ({t, fin, alarma} !== {24'h000001, 2'b00}) begin tests_failed++; $display("FAIL expiry_pre: got %h expected %h", {t, fin, alarma}, {24'h000001, 2'b00}); end
      pulso_tick();
      tests_run++; if ({t, corriendo, fin, alarma} !== {24'h000000, 3'b011}) begin tests_failed++; $display("FAIL expiry_edge: got %h expected %h", {t, corriendo, fin, alarma}, {24'h000000, 3'b011}); end
      paso();
      tests_run++; if ({fin, alarma} !== 2'b10) begin tests_failed++; $display("FAIL expiry_alarm_one_cycle: got %b expected %b", {fin, alarma}, 2'b10); end
      pulso_tick(); pulso_tick();
      tests_run++; if ({t, corriendo, fin, alarma} !== {24'h000000, 3'b010}) begin tests_failed++; $display("FAIL expiry_no_wrap: got %h expected %h", {t, corriendo, fin, alarma}, {24'h000000, 3'b010}); end
      pulso_ack();
      tests_run++; if ({t, fin} !== {24'h000000, 1'b0}) begin tests_failed++; $display("FAIL ack_fin: got %h expected %h", {t, fin}, {24'h000000, 1'b0}); end
      pulso_iniciar();
      tests_run++; if (corriendo !== 1'b0) begin tests_failed++; $display("FAIL start_at_zero: got %b expected %b", corriendo, 1'b0); end
   endtask

   task automatic test_carga_invalida();
      cargar_valor(8'h00, 8'h00, 8'h07);
      tests_run++; if ({t, error_carga} !== {24'h000007, 1'b0}) begin tests_failed++; $display("FAIL valid_load: got %h expected %h", {t, error_carga}, {24'h000007, 1'b0}); end
      cargar_valor(8'h00, 8'h5A, 8'h00);
      tests_run++; if ({t, error_carga} !== {24'h000007, 1'b1}) begin tests_failed++; $display("FAIL bad_nibble: got %h expected %h", {t, error_carga}, {24'h000007, 1'b1}); end
      paso();
      tests_run++; if (error_carga !== 1'b0) begin tests_failed++; $display("FAIL err_one_cycle: got %b expected %b", error_carga, 1'b0); end
      cargar_valor(8'h24, 8'h00, 8'h00);
      tests_run++; if ({t, error_carga} !== {24'h000007, 1'b1}) begin tests_failed++; $display("FAIL hour_too_big: got %h expected %h", {t, error_carga}, {24'h000007, 1'b1}); end
      cargar_valor(8'h23, 8'h59, 8'h59);
      tests_run++; if ({t, error_carga} !== {24'h235959, 1'b0}) begin tests_failed++; $display("FAIL max_load: got %h expected %h", {t, error_carga}, {24'h235959, 1'b0}); end
   endtask

   task automatic test_pausa();
      cargar_valor(8'h00, 8'h00, 8'h30);
      pulso_iniciar();
      pausar = 1'b1; tick_1hz = 1'b1; paso(); pausar = 1'b0; tick_1hz = 1'b0;
      tests_run++; if ({t, corriendo} !== {24'h000030, 1'b0}) begin tests_failed++; $display("FAIL pause_with_tick: got %h expected %h", {t, corriendo}, {24'h000030, 1'b0}); end
      pulso_tick(); pulso_tick(); pulso_tick();
      tests_run++; if ({t, corriendo} !== {24'h000030, 1'b0}) begin tests_failed++; $display("FAIL pause_ticks_ignored: got %h expected %h", {t, corriendo}, {24'h000030, 1'b0}); end
      pulso_iniciar();
      tests_run++; if (corriendo !== 1'b1) begin tests_failed++; $display("FAIL resume: got %b expected %b", corriendo, 1'b1); end
      pulso_tick();
      tests_run++; if (t !== 24'h000029) begin tests_failed++; $display("FAIL resume_tick: got %h expected %h", t, 24'h000029); end
   endtask

   task automatic test_autorecarga();
      cargar_valor(8'h00, 8'h00, 8'h01);
      pulso_iniciar();
      pulso_tick();
      tests_run++; if ({t_ar, ar_corriendo, ar_fin, ar_alarma} !== {24'h000001, 3'b111}) begin tests_failed++; $display("FAIL autoreload_edge: got %h expected %h", {t_ar, ar_corriendo, ar_fin, ar_alarma}, {24'h000001, 3'b111}); end
      paso();
      tests_run++; if ({ar_corriendo, ar_fin, ar_alarma} !== 3'b110) begin tests_failed++; $display("FAIL autoreload_after: got %b expected %b", {ar_corriendo, ar_fin, ar_alarma}, 3'b110); end
      pulso_ack();
      tests_run++; if ({ar_corriendo, ar_fin} !== 2'b10) begin tests_failed++; $display("FAIL autoreload_ack: got %b expected %b", {ar_corriendo, ar_fin}, 2'b10); end
   endtask

   task automatic test_reset_en_marcha();
      cargar_valor(8'h00, 8'h00, 8'h30);
      pulso_iniciar();
      pulso_tick();
      #1;
      reset = 1'b0;
      #1;
      tests_run++; if ({t, corriendo, fin, alarma, error_carga} !== 28'h0) begin tests_failed++; $display("FAIL reset_mid_run: got %h expected %h", {t, corriendo, fin, alarma, error_carga}, 28'h0); end
      paso();
      reset = 1'b1;
      paso(); paso(); paso();
      tests_run++; if ({t, corriendo} !== 25'h0) begin tests_failed++; $display("FAIL reset_mid_run_release: got %h expected %h", {t, corriendo}, 25'h0); end
   endtask

   initial begin
      test_reset();
      test_cuenta_basica();
      test_borrow_hora();
      test_expiracion();
      test_carga_invalida();
      test_pausa();
      test_autorecarga();
      test_reset_en_marcha();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
